// File: rtl/spi_rgbmatrix_pkg.sv
// Shared definitions for the serial-to-HUB75 panel driver.
//   - drv_state_t : panel sequence FSM states.
//   - frame_bits / row_flag_bit / latch_flag_bit / data_msb : frame layout
//     helpers, all derived from CHAN (RGB triplets per panel clock).
// Frame layout, in shift order (MSB first):
//   [FRAME_BITS-1] row flag, [FRAME_BITS-2] latch flag, [3*CHAN-1:0] data.
package spi_rgbmatrix_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        CLKHI = 2'd2,
        LATCH = 2'd3
    } drv_state_t;

    function automatic int frame_bits(input int chan);
        return 3 * chan + 2;
    endfunction

    function automatic int row_flag_bit(input int chan);
        return 3 * chan + 1;
    endfunction

    function automatic int latch_flag_bit(input int chan);
        return 3 * chan;
    endfunction

    function automatic int data_msb(input int chan);
        return 3 * chan - 1;
    endfunction

endpackage

// File: rtl/spi_frame_deserializer.sv
// Frame deserialiser for the panel driver.
// Shifts si in MSB first while cs_n is low and pulses frame_done for one
// cycle after the edge that samples the last bit of a frame; frame then
// holds the complete frame until the next cs_n-low bit is shifted in.
// Raising cs_n realigns framing to bit 0 and silently drops a partial frame.
// Ports:
//   clk, reset  : clock, asynchronous active-high reset
//   si, cs_n    : serial data and active-low frame select
//   frame       : last FRAME_BITS shifted bits (valid when frame_done = 1)
//   frame_done  : one-cycle pulse, complete frame available on frame
module spi_frame_deserializer
    import spi_rgbmatrix_pkg::*;
#(
    parameter  int CHAN       = 2,
    localparam int FRAME_BITS = frame_bits(CHAN)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  si,
    input  logic                  cs_n,
    output logic [FRAME_BITS-1:0] frame,
    output logic                  frame_done
);

    localparam int              CNT_W    = $clog2(FRAME_BITS);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_BITS - 1);

    logic [FRAME_BITS-1:0] sr;
    logic [FRAME_BITS-1:0] sr_next;
    logic [CNT_W-1:0]      bit_cnt;

    assign sr_next = {sr[FRAME_BITS-2:0], si};

    // The shift register already contains the whole frame one cycle after
    // the last bit, which is exactly when frame_done is seen, so no separate
    // frame holding register is needed.
    assign frame = sr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sr         <= '0;
            bit_cnt    <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (cs_n) begin
                bit_cnt <= '0;
            end else begin
                sr <= sr_next;
                if (bit_cnt == LAST_BIT) begin
                    bit_cnt    <= '0;
                    frame_done <= 1'b1;
                end else begin
                    bit_cnt <= bit_cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/spi_rgbmatrix_driver.sv
// Serial-to-HUB75 panel driver.
// Each received frame loads rgbs, produces one clk_out pulse and, if the
// latch flag is set, a latch_out pulse with an oe_out blanking window and an
// optional row advance.
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   si, cs_n   : serial data (MSB first) and active-low frame select
//   rgbs       : panel colour data (3*CHAN bits)
//   row        : panel row address, resets to all ones
//   clk_out    : panel shift clock, one pulse per frame
//   latch_out  : panel latch strobe
//   oe_out     : panel output enable, active-low (1 = blanked)
module spi_rgbmatrix_driver
    import spi_rgbmatrix_pkg::*;
#(
    parameter int CHAN         = 2,
    parameter int ROW_BITS     = 4,
    parameter int BLANK_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  si,
    input  logic                  cs_n,
    output logic [3*CHAN-1:0]     rgbs,
    output logic [ROW_BITS-1:0]   row,
    output logic                  clk_out,
    output logic                  latch_out,
    output logic                  oe_out
);

    localparam int FRAME_BITS = frame_bits(CHAN);
    localparam int ROW_FLAG   = row_flag_bit(CHAN);
    localparam int LATCH_FLAG = latch_flag_bit(CHAN);
    localparam int DATA_MSB   = data_msb(CHAN);
    localparam int BLANK_W    = $clog2(BLANK_CYCLES + 1);
    localparam logic [BLANK_W-1:0] BLANK_LOAD = BLANK_W'(BLANK_CYCLES);

    logic [FRAME_BITS-1:0] frame;
    logic                  frame_done;
    drv_state_t            state;
    logic                  row_flag;
    logic                  latch_flag;
    logic [BLANK_W-1:0]    blank_cnt;

    spi_frame_deserializer #(
        .CHAN (CHAN)
    ) u_deser (
        .clk        (clk),
        .reset      (reset),
        .si         (si),
        .cs_n       (cs_n),
        .frame      (frame),
        .frame_done (frame_done)
    );

    // Outputs are registered from the state being entered, so clk_out is
    // high exactly while in CLKHI and latch_out exactly while in LATCH.
    // rgbs is loaded on SETUP entry, giving one clk of setup before clk_out
    // rises and holding until the next frame's SETUP.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            rgbs       <= '0;
            row        <= '1;
            row_flag   <= 1'b0;
            latch_flag <= 1'b0;
            clk_out    <= 1'b0;
            latch_out  <= 1'b0;
            oe_out     <= 1'b1;
            blank_cnt  <= '0;
        end else begin
            clk_out   <= 1'b0;
            latch_out <= 1'b0;

            // Blanking holds while the counter is non-zero and for the one
            // cycle after it reaches zero; a LATCH entry below overrides this
            // and restarts the window.
            if (blank_cnt != '0) begin
                blank_cnt <= blank_cnt - BLANK_W'(1);
            end else begin
                oe_out <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (frame_done) begin
                        state      <= SETUP;
                        rgbs       <= frame[DATA_MSB:0];
                        row_flag   <= frame[ROW_FLAG];
                        latch_flag <= frame[LATCH_FLAG];
                    end
                end
                SETUP: begin
                    state   <= CLKHI;
                    clk_out <= 1'b1;
                end
                CLKHI: begin
                    if (latch_flag) begin
                        state     <= LATCH;
                        latch_out <= 1'b1;
                        oe_out    <= 1'b1;
                        blank_cnt <= BLANK_LOAD;
                        if (row_flag) begin
                            row <= row + ROW_BITS'(1);
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                LATCH: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // A frame takes at least 5 clks and the panel sequence at most 4, so a
    // frame can never complete while a sequence is still running.
    frame_done_only_in_idle: assert property (
        @(posedge clk) disable iff (reset) frame_done |-> (state == IDLE)
    );

endmodule

// File: tb/tb_spi_rgbmatrix_driver.sv
module tb_spi_rgbmatrix_driver;

    localparam int FB  = 8;
    localparam int B_A = 4;
    localparam int B_B = 12;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       si = 1'b0;
    logic       cs_n = 1'b1;
    logic [5:0] rgbs, rgbs_b;
    logic [3:0] row, row_b;
    logic       clk_out, clk_out_b, latch_out, latch_out_b, oe_out, oe_out_b;

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    spi_rgbmatrix_driver #(.CHAN(2), .ROW_BITS(4), .BLANK_CYCLES(B_A)) dut (
        .clk(clk), .reset(reset), .si(si), .cs_n(cs_n),
        .rgbs(rgbs), .row(row), .clk_out(clk_out),
        .latch_out(latch_out), .oe_out(oe_out)
    );

    spi_rgbmatrix_driver #(.CHAN(2), .ROW_BITS(4), .BLANK_CYCLES(B_B)) dut_b (
        .clk(clk), .reset(reset), .si(si), .cs_n(cs_n),
        .rgbs(rgbs_b), .row(row_b), .clk_out(clk_out_b),
        .latch_out(latch_out_b), .oe_out(oe_out_b)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;   // clk edges since reset release
    int pos      = 0;   // bits of the current frame received
    logic [7:0] cur = '0;

    // Reference model: list of completed frames with the edge E that sampled
    // their last bit; every output is derived from this list.
    typedef struct { int e; logic [7:0] f; } frame_t;
    frame_t frames[$];

    typedef struct {
        int t;
        logic [5:0] rgbs; logic [3:0] row; logic clk_o; logic latch_o; logic oe_a;
        logic [5:0] rgbs_b; logic [3:0] row_b; logic clk_b; logic latch_b; logic oe_b;
    } obs_t;
    obs_t obs[$];

    function automatic logic [5:0] m_rgbs(input int t);
        logic [5:0] r = '0;
        foreach (frames[i]) if (frames[i].e + 1 <= t) r = frames[i].f[5:0];
        return r;
    endfunction

    function automatic logic m_clk(input int t);
        foreach (frames[i]) if (frames[i].e + 2 == t) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic m_latch(input int t);
        foreach (frames[i]) if (frames[i].f[6] && frames[i].e + 3 == t) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [3:0] m_row(input int t);
        int n = 0;
        foreach (frames[i]) if (frames[i].f[7] && frames[i].f[6] && frames[i].e + 3 <= t) n++;
        return 4'((15 + n) % 16);
    endfunction

    function automatic logic m_oe(input int t, input int b);
        if (t == 0) return 1'b1;
        foreach (frames[i])
            if (frames[i].f[6] && t >= frames[i].e + 3 && t <= frames[i].e + 3 + b) return 1'b1;
        return 1'b0;
    endfunction

    // ---------------- reset / drivers ----------------
    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; cs_n = 1'b1; si = 1'b0;
        #2;
        frames.delete(); obs.delete();
        cyc = 0; pos = 0; cur = '0;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic drive_bit(input logic c, input logic d);
        @(negedge clk);
        cs_n = c; si = d;
        @(posedge clk); #1;
        cyc++;
        if (c) begin
            pos = 0;
        end else begin
            cur = {cur[6:0], d};
            pos++;
            if (pos == FB) begin
                frames.push_back('{cyc, cur});
                pos = 0;
            end
        end
        obs.push_back('{cyc, rgbs, row, clk_out, latch_out, oe_out,
                        rgbs_b, row_b, clk_out_b, latch_out_b, oe_out_b});
    endtask

    task automatic send_frame(input logic [7:0] f);
        for (int i = FB - 1; i >= 0; i--) drive_bit(1'b0, f[i]);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive_bit(1'b1, 1'($urandom_range(0, 1)));
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        do_reset();
        n_checks++; if (rgbs !== 6'd0) $display("FAIL reset_rgbs got=%h exp=00", rgbs); else n_pass++;
        n_checks++; if (row !== 4'd15) $display("FAIL reset_row got=%0d exp=15", row); else n_pass++;
        n_checks++; if (clk_out !== 1'b0) $display("FAIL reset_clk_out got=%b exp=0", clk_out); else n_pass++;
        n_checks++; if (latch_out !== 1'b0) $display("FAIL reset_latch got=%b exp=0", latch_out); else n_pass++;
        n_checks++; if (oe_out !== 1'b1) $display("FAIL reset_oe got=%b exp=1", oe_out); else n_pass++;
        n_checks++; if (row_b !== 4'd15) $display("FAIL reset_row_b got=%0d exp=15", row_b); else n_pass++;
        n_checks++; if (oe_out_b !== 1'b1) $display("FAIL reset_oe_b got=%b exp=1", oe_out_b); else n_pass++;
        idle(1);
        n_checks++; if (oe_out !== 1'b0) $display("FAIL reset_oe_release got=%b exp=0", oe_out); else n_pass++;
    endtask

    task automatic test_frames();
        int pulses = 0;
        do_reset();
        idle(3);
        send_frame(8'b00_101010);
        idle(6);
        n_checks++; if (rgbs !== 6'b101010) $display("FAIL frame1_rgbs got=%b exp=101010", rgbs); else n_pass++;
        n_checks++; if (row !== 4'd15) $display("FAIL frame1_row got=%0d exp=15", row); else n_pass++;
        send_frame(8'b11_000111);
        idle(8);
        n_checks++; if (row !== 4'd0) $display("FAIL frame2_row got=%0d exp=0", row); else n_pass++;
        for (int i = 0; i < 16; i++) send_frame({2'b11, 6'($urandom_range(0, 63))});
        idle(8);
        n_checks++; if (row !== 4'd0) $display("FAIL row_wrap got=%0d exp=0", row); else n_pass++;
        // partial frame of 5 bits, then a latch-only frame
        for (int i = 0; i < 5; i++) drive_bit(1'b0, 1'b0);
        idle(1);
        send_frame(8'b01_111111);
        idle(8);
        n_checks++; if (rgbs !== 6'b111111) $display("FAIL partial_rgbs got=%b exp=111111", rgbs); else n_pass++;
        n_checks++; if (row !== 4'd0) $display("FAIL partial_row got=%0d exp=0", row); else n_pass++;
        foreach (obs[i]) begin
            if (obs[i].clk_o === 1'b1) pulses++;
            n_checks++; if (obs[i].rgbs !== m_rgbs(obs[i].t)) $display("FAIL frames_rgbs t=%0d got=%h exp=%h", obs[i].t, obs[i].rgbs, m_rgbs(obs[i].t)); else n_pass++;
            n_checks++; if (obs[i].clk_o !== m_clk(obs[i].t)) $display("FAIL frames_clk t=%0d got=%b exp=%b", obs[i].t, obs[i].clk_o, m_clk(obs[i].t)); else n_pass++;
            n_checks++; if (obs[i].latch_o !== m_latch(obs[i].t)) $display("FAIL frames_latch t=%0d got=%b exp=%b", obs[i].t, obs[i].latch_o, m_latch(obs[i].t)); else n_pass++;
            n_checks++; if (obs[i].row !== m_row(obs[i].t)) $display("FAIL frames_row t=%0d got=%0d exp=%0d", obs[i].t, obs[i].row, m_row(obs[i].t)); else n_pass++;
        end
        // 1 + 1 + 16 + 1 complete frames were sent
        n_checks++; if (pulses != 19) $display("FAIL clk_pulse_count got=%0d exp=19", pulses); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int high_b = 0;
        do_reset();
        idle(2);
        send_frame({2'b11, 6'($urandom_range(0, 63))});
        send_frame({2'b11, 6'($urandom_range(0, 63))});
        idle(20);
        foreach (obs[i]) begin
            if (obs[i].oe_b === 1'b1) high_b++;
            n_checks++; if (obs[i].oe_a !== m_oe(obs[i].t, B_A)) $display("FAIL b2b_oe t=%0d got=%b exp=%b", obs[i].t, obs[i].oe_a, m_oe(obs[i].t, B_A)); else n_pass++;
            n_checks++; if (obs[i].oe_b !== m_oe(obs[i].t, B_B)) $display("FAIL b2b_oe_b t=%0d got=%b exp=%b", obs[i].t, obs[i].oe_b, m_oe(obs[i].t, B_B)); else n_pass++;
        end
        // latches 8 clks apart, window from first latch through 12 after the second
        n_checks++; if (high_b != 21) $display("FAIL b2b_blank_len got=%0d exp=21", high_b); else n_pass++;
    endtask

    task automatic test_random();
        do_reset();
        idle(2);
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 19) == 0) drive_bit(1'b1, 1'($urandom_range(0, 1)));
            else drive_bit(1'b0, 1'($urandom_range(0, 1)));
        end
        idle(20);
        foreach (obs[i]) begin
            n_checks++; if (obs[i].rgbs !== m_rgbs(obs[i].t) || obs[i].rgbs_b !== m_rgbs(obs[i].t)) $display("FAIL rand_rgbs t=%0d got=%h/%h exp=%h", obs[i].t, obs[i].rgbs, obs[i].rgbs_b, m_rgbs(obs[i].t)); else n_pass++;
            n_checks++; if (obs[i].clk_o !== m_clk(obs[i].t) || obs[i].clk_b !== m_clk(obs[i].t)) $display("FAIL rand_clk t=%0d got=%b/%b exp=%b", obs[i].t, obs[i].clk_o, obs[i].clk_b, m_clk(obs[i].t)); else n_pass++;
            n_checks++; if (obs[i].latch_o !== m_latch(obs[i].t) || obs[i].latch_b !== m_latch(obs[i].t)) $display("FAIL rand_latch t=%0d got=%b/%b exp=%b", obs[i].t, obs[i].latch_o, obs[i].latch_b, m_latch(obs[i].t)); else n_pass++;
            n_checks++; if (obs[i].row !== m_row(obs[i].t) || obs[i].row_b !== m_row(obs[i].t)) $display("FAIL rand_row t=%0d got=%0d/%0d exp=%0d", obs[i].t, obs[i].row, obs[i].row_b, m_row(obs[i].t)); else n_pass++;
            n_checks++; if (obs[i].oe_a !== m_oe(obs[i].t, B_A)) $display("FAIL rand_oe t=%0d got=%b exp=%b", obs[i].t, obs[i].oe_a, m_oe(obs[i].t, B_A)); else n_pass++;
            n_checks++; if (obs[i].oe_b !== m_oe(obs[i].t, B_B)) $display("FAIL rand_oe_b t=%0d got=%b exp=%b", obs[i].t, obs[i].oe_b, m_oe(obs[i].t, B_B)); else n_pass++;
        end
    endtask

    task automatic test_reset_in_clkhi();
        do_reset();
        idle(2);
        send_frame(8'b11_010101);
        idle(2);   // now just after E+2: clk_out high
        n_checks++; if (clk_out !== 1'b1) $display("FAIL clkhi_before_reset got=%b exp=1", clk_out); else n_pass++;
        #1 reset = 1'b1;
        #1;
        n_checks++; if (clk_out !== 1'b0) $display("FAIL async_reset_clk_out got=%b exp=0", clk_out); else n_pass++;
        n_checks++; if (rgbs !== 6'd0) $display("FAIL async_reset_rgbs got=%h exp=00", rgbs); else n_pass++;
        n_checks++; if (row !== 4'd15) $display("FAIL async_reset_row got=%0d exp=15", row); else n_pass++;
        n_checks++; if (oe_out !== 1'b1) $display("FAIL async_reset_oe got=%b exp=1", oe_out); else n_pass++;
        n_checks++; if (latch_out !== 1'b0) $display("FAIL async_reset_latch got=%b exp=0", latch_out); else n_pass++;
        // sequence must not resume after release; a fresh frame works normally
        do_reset();
        idle(6);
        n_checks++; if (latch_out !== 1'b0 || row !== 4'd15) $display("FAIL post_reset_quiet got=%b/%0d exp=0/15", latch_out, row); else n_pass++;
        send_frame(8'b11_110011);
        idle(3);
        n_checks++; if (row !== 4'd0 || rgbs !== 6'b110011) $display("FAIL post_reset_frame got=%0d/%b exp=0/110011", row, rgbs); else n_pass++;
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_frames();
        test_back_to_back();
        test_random();
        test_reset_in_clkhi();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
